// File: rtl/double_pkg.sv
// Shared state encoding, IEEE-754 double constants and unpack helpers
// for the double-precision dot-product accumulator.
package double_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_TERM = 4'd1,
    SPECIAL   = 4'd2,
    ALIGN     = 4'd3,
    ADD       = 4'd4,
    NORM      = 4'd5,
    ROUND     = 4'd6,
    PACK      = 4'd7,
    DONE      = 4'd8
  } state_t;

  localparam logic signed [12:0] DBL_BIAS    = 13'sd1023;
  localparam logic [63:0]        DBL_QNAN    = 64'hFFF8000000000000;
  localparam logic [63:0]        DBL_POS_INF = 64'h7FF0000000000000;
  localparam logic [63:0]        DBL_ZERO    = 64'h0000000000000000;
  localparam logic signed [12:0] EXP_MIN     = -13'sd1022;
  localparam logic signed [12:0] EXP_MAX     = 13'sd1023;
  localparam logic signed [12:0] EXP_SPECIAL = 13'sd1024;
  localparam logic signed [12:0] EXP_DENORM  = -13'sd1023;

  function automatic logic signed [12:0] unbias(input logic [10:0] field);
    return $signed({2'b00, field}) - DBL_BIAS;
  endfunction

  // Denormals live at the minimum exponent without a hidden bit.
  function automatic logic signed [12:0] eff_exp(input logic signed [12:0] exp);
    return (exp == EXP_DENORM) ? EXP_MIN : exp;
  endfunction

  // Layout: hidden bit, 52-bit fraction, guard, round, sticky.
  function automatic logic [55:0] ext_sig(input logic signed [12:0] exp, input logic [51:0] man);
    return {(exp != EXP_DENORM), man, 3'b000};
  endfunction

endpackage

// File: rtl/lzc56.sv
// Leading-zero count of a 56-bit significand; an all-zero input reports 56.
module lzc56 (
  input  logic [55:0] vec,
  output logic [5:0]  count
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    count = 6'd56;
    for (int i = 0; i < 56; i++) begin
      count = vec[i] ? 6'(55 - i) : count;
    end
  end

endmodule

// File: rtl/double_accumulate.sv
// Sequential IEEE-754 double accumulator: sums a stream of terms, one
// round-to-nearest-even addition every seven cycles, in arrival order.
module double_accumulate
  import double_pkg::*;
#(
  parameter int MAX_LEN = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_LEN+1)-1:0]   length,
  input  logic [63:0]                    in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [63:0]                    sum_out,
  output logic                           sum_done
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t state_r, state_next_s;
  logic [LEN_W-1:0] remaining_r;
  logic [63:0] acc_r;
  logic ready_r, done_r;

  logic term_sign_r;
  logic signed [12:0] term_exp_r;
  logic [51:0] term_man_r;

  logic big_sign_r, small_sign_r, work_sign_r;
  logic signed [12:0] big_exp_r, small_exp_r, work_exp_r;
  logic [55:0] big_sig_r, small_sig_r;
  logic [56:0] work_sig_r;
  logic force_r;
  logic [63:0] force_val_r;

  logic signed [12:0] acc_exp_s;
  logic acc_inf_s, acc_nan_s, term_inf_s, term_nan_s, acc_big_s;
  logic force_s;
  logic [63:0] force_val_s;
  logic big_sign_s, small_sign_s;
  logic signed [12:0] big_exp_s, small_exp_s;
  logic [55:0] big_sig_s, small_sig_s;

  logic signed [12:0] diff_s;
  logic [55:0] lost_mask_s, align_sig_s;
  logic [56:0] add_sig_s;
  logic add_sign_s;

  logic [5:0] lz_s, shift_s;
  logic signed [12:0] limit_s, norm_exp_s, round_exp_s;
  logic [55:0] norm_sig_s;
  logic inc_s;
  logic [53:0] round_sum_s;
  logic [52:0] round_sig_s;
  logic [63:0] pack_val_s;

  lzc56 u_lzc (
    .vec   (work_sig_r[55:0]),
    .count (lz_s)
  );

  assign in_ready = ready_r;
  assign sum_done = done_r;
  assign sum_out  = acc_r;

  // Special-operand screening and larger/smaller magnitude ordering.
  always_comb begin
    acc_exp_s  = unbias(acc_r[62:52]);
    acc_inf_s  = (acc_r[62:52] == 11'h7FF) && (acc_r[51:0] == 52'd0);
    acc_nan_s  = (acc_r[62:52] == 11'h7FF) && (acc_r[51:0] != 52'd0);
    term_inf_s = (term_exp_r == EXP_SPECIAL) && (term_man_r == 52'd0);
    term_nan_s = (term_exp_r == EXP_SPECIAL) && (term_man_r != 52'd0);
    // Finite doubles order by magnitude exactly as their raw bit patterns do.
    acc_big_s  = acc_r[62:0] >= {11'(term_exp_r + DBL_BIAS), term_man_r};

    if (acc_nan_s || term_nan_s) begin
      force_s = 1'b1;  force_val_s = DBL_QNAN;
    end else if (acc_inf_s && term_inf_s && (acc_r[63] != term_sign_r)) begin
      force_s = 1'b1;  force_val_s = DBL_QNAN;
    end else if (acc_inf_s) begin
      force_s = 1'b1;  force_val_s = acc_r;
    end else if (term_inf_s) begin
      force_s = 1'b1;  force_val_s = {term_sign_r, DBL_POS_INF[62:0]};
    end else begin
      force_s = 1'b0;  force_val_s = DBL_ZERO;
    end

    if (acc_big_s) begin
      big_sign_s   = acc_r[63];
      big_exp_s    = eff_exp(acc_exp_s);
      big_sig_s    = ext_sig(acc_exp_s, acc_r[51:0]);
      small_sign_s = term_sign_r;
      small_exp_s  = eff_exp(term_exp_r);
      small_sig_s  = ext_sig(term_exp_r, term_man_r);
    end else begin
      big_sign_s   = term_sign_r;
      big_exp_s    = eff_exp(term_exp_r);
      big_sig_s    = ext_sig(term_exp_r, term_man_r);
      small_sign_s = acc_r[63];
      small_exp_s  = eff_exp(acc_exp_s);
      small_sig_s  = ext_sig(acc_exp_s, acc_r[51:0]);
    end
  end

  // Alignment shift with sticky collection, then magnitude add/subtract.
  always_comb begin
    diff_s      = big_exp_r - small_exp_r;
    lost_mask_s = ~({56{1'b1}} << diff_s[5:0]);
    if (diff_s >= 13'sd56) begin
      align_sig_s = {55'd0, (small_sig_r != 56'd0)};
    end else begin
      align_sig_s = (small_sig_r >> diff_s[5:0]) | {55'd0, |(small_sig_r & lost_mask_s)};
    end

    if (big_sign_r == small_sign_r) begin
      add_sig_s = {1'b0, big_sig_r} + {1'b0, small_sig_r};
    end else begin
      add_sig_s = {1'b0, big_sig_r} - {1'b0, small_sig_r};
    end
    add_sign_s = (add_sig_s == 57'd0) ? (big_sign_r & small_sign_r) : big_sign_r;
  end

  // Normalisation, round-to-nearest-even and final packing.
  always_comb begin
    limit_s = work_exp_r - EXP_MIN;
    shift_s = ($signed({7'd0, lz_s}) > limit_s) ? 6'(limit_s) : lz_s;
    if (work_sig_r[56]) begin
      norm_sig_s = {work_sig_r[56:2], work_sig_r[1] | work_sig_r[0]};
      norm_exp_s = work_exp_r + 13'sd1;
    end else begin
      norm_sig_s = work_sig_r[55:0] << shift_s;
      norm_exp_s = work_exp_r - $signed({7'd0, shift_s});
    end

    inc_s       = work_sig_r[2] & (work_sig_r[1] | work_sig_r[0] | work_sig_r[3]);
    round_sum_s = {1'b0, work_sig_r[55:3]} + {53'd0, inc_s};
    if (round_sum_s[53]) begin
      round_sig_s = round_sum_s[53:1];
      round_exp_s = work_exp_r + 13'sd1;
    end else begin
      round_sig_s = round_sum_s[52:0];
      round_exp_s = work_exp_r;
    end

    if (work_exp_r > EXP_MAX) begin
      pack_val_s = {work_sign_r, DBL_POS_INF[62:0]};
    end else if (work_sig_r[52]) begin
      pack_val_s = {work_sign_r, 11'(work_exp_r + DBL_BIAS), work_sig_r[51:0]};
    end else begin
      pack_val_s = {work_sign_r, 11'd0, work_sig_r[51:0]};
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_next_s = (length == {LEN_W{1'b0}}) ? DONE : WAIT_TERM;
        else       state_next_s = state_r;
      end
      WAIT_TERM: begin
        if (in_valid) state_next_s = SPECIAL;
        else          state_next_s = WAIT_TERM;
      end
      SPECIAL: state_next_s = force_s ? PACK : ALIGN;
      ALIGN:   state_next_s = ADD;
      ADD:     state_next_s = NORM;
      NORM:    state_next_s = ROUND;
      ROUND:   state_next_s = PACK;
      PACK:    state_next_s = (remaining_r == {LEN_W{1'b0}}) ? DONE : WAIT_TERM;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and registered handshake/done flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == WAIT_TERM);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Datapath registers, each stage writing only in its own state.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining_r  <= {LEN_W{1'b0}};
      acc_r        <= DBL_ZERO;
      term_sign_r  <= 1'b0;
      term_exp_r   <= 13'sd0;
      term_man_r   <= 52'd0;
      big_sign_r   <= 1'b0;
      big_exp_r    <= 13'sd0;
      big_sig_r    <= 56'd0;
      small_sign_r <= 1'b0;
      small_exp_r  <= 13'sd0;
      small_sig_r  <= 56'd0;
      work_sign_r  <= 1'b0;
      work_exp_r   <= 13'sd0;
      work_sig_r   <= 57'd0;
      force_r      <= 1'b0;
      force_val_r  <= DBL_ZERO;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            acc_r       <= DBL_ZERO;
            remaining_r <= length;
          end
        end
        WAIT_TERM: begin
          if (in_valid) begin
            term_sign_r <= in_data[63];
            term_exp_r  <= unbias(in_data[62:52]);
            term_man_r  <= in_data[51:0];
            remaining_r <= remaining_r - {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        SPECIAL: begin
          force_r      <= force_s;
          force_val_r  <= force_val_s;
          big_sign_r   <= big_sign_s;
          big_exp_r    <= big_exp_s;
          big_sig_r    <= big_sig_s;
          small_sign_r <= small_sign_s;
          small_exp_r  <= small_exp_s;
          small_sig_r  <= small_sig_s;
        end
        ALIGN: small_sig_r <= align_sig_s;
        ADD: begin
          work_sig_r  <= add_sig_s;
          work_sign_r <= add_sign_s;
          work_exp_r  <= big_exp_r;
        end
        NORM: begin
          work_sig_r <= {1'b0, norm_sig_s};
          work_exp_r <= norm_exp_s;
        end
        ROUND: begin
          work_sig_r <= {4'd0, round_sig_s};
          work_exp_r <= round_exp_s;
        end
        PACK: acc_r <= force_r ? force_val_r : pack_val_s;
        default: acc_r <= acc_r;
      endcase
    end
  end

endmodule

// File: doc/double_accumulate.md
DOUBLE_ACCUMULATE -- requirements
Module: double_accumulate

Interface
REQ-001 Parameter MAX_LEN, default 255, meaning the largest legal term count; the length port width is $clog2(MAX_LEN+1).
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a new dot product; sampled only in IDLE or DONE.
REQ-005 length  input  8  number of terms to sum; sampled with start.
REQ-006 in_data  input  64  IEEE-754 double term, normally a multiplier product.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts a term this cycle.
REQ-009 sum_out  output  64  accumulated IEEE-754 double.
REQ-010 sum_done  output  1  sum_out is final; held high while in DONE.

Function
REQ-011 States SHALL be IDLE, WAIT_TERM, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK and DONE.
REQ-012 Transitions from IDLE or DONE on start:
- length==0 -> DONE with accumulator +0.0.
- otherwise -> WAIT_TERM, with accumulator = +0.0 and remaining = length.
REQ-013 in_ready SHALL equal (state==WAIT_TERM); a term is accepted on in_valid && in_ready, and in_data is unpacked (sign, exponent minus 1023, mantissa) into registers in that cycle.
REQ-014 Sequencing after a term is accepted in cycle T:
- SPECIAL at T+1, ALIGN at T+2, ADD at T+3, NORM at T+4, ROUND at T+5, PACK at T+6.
- At T+7 the state is WAIT_TERM if remaining>0 after decrement; otherwise it is DONE.
- Term throughput is therefore one term per 7 cycles.
REQ-015 SPECIAL SHALL apply these rules, each skipping to PACK with a forced result:
- NaN on either operand -> 0xFFF8000000000000.
- +inf + -inf -> 0xFFF8000000000000.
- Single inf -> that inf.
Denormals SHALL take exponent -1022 with hidden bit 0; normals take hidden bit 1.
REQ-016 ALIGN SHALL right-shift the smaller-exponent mantissa by the exponent difference, in one cycle.
- Operands are extended with guard, round and sticky bits.
- Shifts of 56 or more SHALL leave only sticky set.
REQ-017 ADD SHALL add the magnitudes when the signs are equal and subtract the smaller from the larger otherwise.
- The result sign is the sign of the larger magnitude.
- An exact zero result SHALL be +0.0, or -0.0 if both operands are negative.
REQ-018 NORM SHALL, in one cycle, do one of the following:
- Right-shift by 1 on carry-out, with exponent +1 and sticky kept.
- Left-shift by the leading-zero count, limited so the exponent does not go below -1022; a result that stays subnormal keeps hidden bit 0.
REQ-019 ROUND SHALL use round-to-nearest-even: increment when guard && (round||sticky||lsb).
- Mantissa overflow SHALL increment the exponent.
REQ-020 PACK SHALL:
- Write the biased result into the accumulator.
- Use exponent field 0 for subnormals.
- Return +/-inf (mantissa 0) when the exponent exceeds 1023.
REQ-021 sum_out SHALL equal the accumulator register at all times; sum_done = (state==DONE).
REQ-022 in_valid outside WAIT_TERM SHALL be ignored.
REQ-023 start outside IDLE or DONE SHALL be ignored.
REQ-024 start in DONE SHALL restart, and sum_done SHALL drop the next cycle.
REQ-025 Terms SHALL be added in arrival order, and each addition SHALL be rounded individually.

Reset
REQ-026 On reset, the state SHALL go to IDLE, all datapath registers to 0, sum_out to 0x0000000000000000, sum_done to 0 and in_ready to 0.
REQ-027 Reset mid-sequence SHALL discard the partial sum and any in-flight term, with no output pulse.

Structure
REQ-028 Package double_pkg SHALL hold:
- the state enum;
- DBL_BIAS=1023;
- DBL_QNAN=64'hFFF8000000000000;
- DBL_POS_INF=64'h7FF0000000000000;
- DBL_ZERO.
REQ-029 One combinational sub-module, lzc56, SHALL supply the 6-bit leading-zero count used by NORM.

Verification
REQ-030 Sum test: start, length=3, terms 0x3FF0000000000000, 0x4000000000000000, 0x3FE0000000000000 -> sum_out 0x400C000000000000; sum_done high 7 cycles after the third accept.
REQ-031 Cancellation test: length=2, terms 0x3FF0000000000000 and 0xBFF0000000000000 -> sum_out 0x0000000000000000.
REQ-032 Specials and overflow tests:
- length=2, terms 0x7FF0000000000000 and 0xFFF0000000000000 -> 0xFFF8000000000000.
- length=2, term 0x7FEFFFFFFFFFFFFF twice -> 0x7FF0000000000000.
REQ-033 Rounding test: length=2, terms 0x3FF0000000000000 and 0x3CA0000000000000 (a tie) -> 0x3FF0000000000000 (rounded to even).
REQ-034 Control tests:
- length=0 -> sum_done high one cycle after start, with sum_out 0.
- Reset asserted at ADD of term 2 of 3 -> IDLE, sum_out 0, and a restarted length=1 run returns that term unchanged.
